// File: rtl/execute_muldiv_unit.sv
// HI/LO multiply/divide unit for the Execute stage: 32-cycle shift-add multiply and restoring divide.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle combinational MULT/MULTU, divide unchanged.
module execute_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_E,
  input  logic [2:0]        op_E,
  input  logic [DATA_W-1:0] src_a_E,
  input  logic [DATA_W-1:0] src_b_E,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t              r_state;
  logic [5:0]          r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_opa;     // multiplicand magnitude
  logic [DATA_W-1:0]   r_opb;     // divisor magnitude
  logic [2*DATA_W-1:0] r_acc;     // product, or dividend shifting into quotient
  logic [DATA_W-1:0]   r_rem;
  logic                r_is_div;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_div0;
`ifdef MULDIV_FAST_MULT_EN
  logic                r_fast;
`endif

  // Operand conditioning at acceptance
  logic              w_is_signed;
  logic              w_is_div;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [DATA_W-1:0] w_mag_a;
  logic [DATA_W-1:0] w_mag_b;

  assign w_is_signed = (op_E == OP_MULT) || (op_E == OP_DIV);
  assign w_is_div    = (op_E == OP_DIV) || (op_E == OP_DIVU);
  assign w_sign_a    = w_is_signed & src_a_E[DATA_W-1];
  assign w_sign_b    = w_is_signed & src_b_E[DATA_W-1];
  assign w_mag_a     = w_sign_a ? ({DATA_W{1'b0}} - src_a_E) : src_a_E;
  assign w_mag_b     = w_sign_b ? ({DATA_W{1'b0}} - src_b_E) : src_b_E;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*DATA_W-1:0] w_fast_prod;
  assign w_fast_prod = {{DATA_W{1'b0}}, w_mag_a} * {{DATA_W{1'b0}}, w_mag_b};
`endif

  // One shift-add multiply step: carry out of the upper half is kept in the 33-bit sum
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_opa};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[DATA_W-1:1]}
                               : {1'b0, r_acc[2*DATA_W-1:1]};

  // One restoring divide step on a 33-bit partial remainder
  logic [DATA_W:0] w_div_shift;
  logic [DATA_W:0] w_div_diff;
  logic            w_div_ok;
  assign w_div_shift = {r_rem, r_acc[DATA_W-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_ok    = ~w_div_diff[DATA_W];

  // Sign correction applied in FIX
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  assign w_prod_fix = r_neg_q ? ({(2*DATA_W){1'b0}} - r_acc) : r_acc;
  assign w_quo_fix  = r_div0  ? {DATA_W{1'b1}}
                    : (r_neg_q ? ({DATA_W{1'b0}} - r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0]);
  assign w_rem_fix  = r_neg_r ? ({DATA_W{1'b0}} - r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {DATA_W{1'b0}};
      r_lo     <= {DATA_W{1'b0}};
      r_opa    <= {DATA_W{1'b0}};
      r_opb    <= {DATA_W{1'b0}};
      r_acc    <= {(2*DATA_W){1'b0}};
      r_rem    <= {DATA_W{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
`ifdef MULDIV_FAST_MULT_EN
      r_fast   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        // Abort: HI/LO untouched, no done pulse, new starts on this edge dropped
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= 6'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
            if (start_E) begin
              case (op_E)
                OP_MTHI: r_hi <= src_a_E;
                OP_MTLO: r_lo <= src_a_E;
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  r_busy   <= 1'b1;
                  r_cnt    <= 6'd0;
                  r_is_div <= w_is_div;
                  r_opa    <= w_mag_a;
                  r_opb    <= w_mag_b;
                  r_rem    <= {DATA_W{1'b0}};
                  r_neg_q  <= w_sign_a ^ w_sign_b;
                  r_neg_r  <= w_sign_a;
                  r_div0   <= w_is_div && (src_b_E == {DATA_W{1'b0}});
                  r_acc    <= w_is_div ? {{DATA_W{1'b0}}, w_mag_a}
                                       : {{DATA_W{1'b0}}, w_mag_b};
                  r_state  <= S_ITER;
`ifdef MULDIV_FAST_MULT_EN
                  r_fast   <= ~w_is_div;
                  if (!w_is_div) begin
                    r_acc   <= w_fast_prod;
                    r_state <= S_FIX;
                  end
`endif
                end
                default: ;
              endcase
            end
          end
          S_ITER: begin
            r_cnt <= r_cnt + 6'd1;
            if (r_is_div) begin
              r_rem <= w_div_ok ? w_div_diff[DATA_W-1:0] : w_div_shift[DATA_W-1:0];
              r_acc <= {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-2:0], w_div_ok};
            end else begin
              r_acc <= w_mul_next;
            end
            if (r_cnt == 6'd31) begin
              r_state <= S_FIX;
            end
          end
          S_FIX: begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
              r_lo <= w_prod_fix[DATA_W-1:0];
            end
            r_done  <= 1'b1;
            // Iterative ops keep the stall through the done cycle
            r_busy  <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
            if (r_fast) begin
              r_busy <= 1'b0;
            end
`endif
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed bench for execute_muldiv_unit: hand-computed HI/LO results, busy/done timing, flush and reset.
module tb_execute_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start_E;
  logic [2:0]  op_E;
  logic [31:0] src_a_E;
  logic [31:0] src_b_E;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  execute_muldiv_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_E(start_E), .op_E(op_E),
    .src_a_E(src_a_E), .src_b_E(src_b_E), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .o_dbg_state(o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issues a start at the current negedge and watches a fixed 40-cycle window.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int          busy_cnt;
    int          done_cnt;
    int          done_idx;
    int          exp_busy;
    int          exp_idx;
    logic [31:0] hi_d;
    logic [31:0] lo_d;
    exp_busy = 34;
    exp_idx  = 33;
`ifdef MULDIV_FAST_MULT_EN
    if (!op[1]) begin
      exp_busy = 1;
      exp_idx  = 1;
    end
`endif
    start_E = 1'b1; op_E = op; src_a_E = a; src_b_E = b;
    @(negedge clk);
    start_E = 1'b0; src_a_E = $urandom; src_b_E = $urandom;
    busy_cnt = 0; done_cnt = 0; done_idx = -1; hi_d = 32'd0; lo_d = 32'd0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_idx = i;
        hi_d = hi;
        lo_d = lo;
      end
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, busy_cnt, exp_busy);
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".done_cycle"}, done_idx, exp_idx);
    check({tag, ".hi"}, hi_d, exp_hi);
    check({tag, ".lo"}, lo_d, exp_lo);
  endtask

  initial begin
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    rst_n = 1'b0; start_E = 1'b0; op_E = 3'd0; src_a_E = 32'd0; src_b_E = 32'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.hi", hi, 0);
    check("reset.lo", lo, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.state", o_dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult_neg", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_-7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7/-2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_100/0", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_-5/0", 3'b010, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_max/7", 3'b011, 32'hFFFF_FFFF, 32'd7, 32'h0000_0003, 32'h2492_4924);

    // Flush in the middle of a divide, then restart immediately
    prev_hi = hi;
    prev_lo = lo;
    start_E = 1'b1; op_E = 3'b011; src_a_E = 32'd1000; src_b_E = 32'd3;
    @(negedge clk);
    start_E = 1'b0;
    check("flush.busy_before", busy, 1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.busy_after", busy, 0);
    check("flush.done", done, 0);
    check("flush.state", o_dbg_state, 0);
    check("flush.hi_kept", hi, prev_hi);
    check("flush.lo_kept", lo, prev_lo);
    run_op("divu_after_flush", 3'b011, 32'd1000, 32'd7, 32'd6, 32'd142);

    // Moves to HI/LO: immediate, never busy, no done
    start_E = 1'b1; op_E = 3'b101; src_a_E = 32'h1234_5678;
    @(negedge clk);
    start_E = 1'b0;
    check("mtlo.lo", lo, 32'h1234_5678);
    check("mtlo.hi_kept", hi, 32'd6);
    check("mtlo.busy", busy, 0);
    check("mtlo.done", done, 0);
    start_E = 1'b1; op_E = 3'b100; src_a_E = 32'hCAFE_0001;
    @(negedge clk);
    start_E = 1'b0;
    check("mthi.hi", hi, 32'hCAFE_0001);
    check("mthi.busy", busy, 0);
    @(negedge clk);
    check("mthi.done_later", done, 0);

    // Reset in the middle of a multiply
    start_E = 1'b1; op_E = 3'b001; src_a_E = 32'd12345; src_b_E = 32'd678;
    @(negedge clk);
    start_E = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst.state_iter", o_dbg_state, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.hi", hi, 0);
    check("midrst.lo", lo, 0);
    check("midrst.busy", busy, 0);
    check("midrst.state", o_dbg_state, 0);
    repeat (40) @(negedge clk);
    check("midrst.no_done", done, 0);
    check("midrst.lo_stays", lo, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
EXECUTE_MULDIV_UNIT -- requirements
Module: execute_muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and HI/LO width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the clock.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-004 The block SHALL have port start_E, input, 1, a one-cycle request from Execute for a HI/LO instruction that has not been squashed.
REQ-005 The block SHALL have port op_E, input, 3, encoded as 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are ignored.
REQ-006 The block SHALL have port src_a_E, input, DATA_W, the forwarded rs operand (dividend / multiplicand / move source).
REQ-007 The block SHALL have port src_b_E, input, DATA_W, the forwarded rt operand (divisor / multiplier).
REQ-008 The block SHALL have port flush, input, 1, which aborts any operation in flight.
REQ-009 The block SHALL have port busy, output, 1, which drives the hazard unit stall (Decode/Execute EN low) while high.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse when HI/LO has been updated by a multiply or divide.
REQ-011 The block SHALL have port hi, output, DATA_W, the architectural HI register, read by MFHI.
REQ-012 The block SHALL have port lo, output, DATA_W, the architectural LO register, read by MFLO.

Function
REQ-013 The FSM SHALL have three states: IDLE, ITER and FIX.
REQ-014 In IDLE, start_E with op MULT/MULTU/DIV/DIVU SHALL latch operand magnitudes and the signed/unsigned flag, clear the 6-bit iteration counter, and move to ITER.
REQ-015 ITER SHALL run exactly 32 cycles, doing one shift-add (multiply) or one restoring shift-subtract (divide) per cycle, then move to FIX.
REQ-016 FIX SHALL apply sign correction, write hi/lo, pulse done, and move to IDLE, all on the same edge.
REQ-017 For a start accepted at edge t0, busy SHALL be high from t0 through t0+33, hi/lo SHALL be valid after edge t0+33, and done SHALL be high in the cycle after that edge.
REQ-018 Signed operations SHALL use magnitudes; the product or quotient SHALL be negated when operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-019 Multiply SHALL place the 64-bit product as {hi, lo}; divide SHALL place the quotient in lo and the remainder in hi.
REQ-020 Division by zero SHALL produce lo = 32'hFFFF_FFFF and hi = src_a_E, with no trap.
REQ-021 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL produce lo = 32'h8000_0000 and hi = 0.
REQ-022 MTHI/MTLO in IDLE SHALL write hi or lo from src_a_E on the accepting edge, with no busy and no done.
REQ-023 start_E while not in IDLE SHALL be ignored; the hazard unit prevents this case.
REQ-024 flush in ITER or FIX SHALL return the FSM to IDLE on the next edge, leave hi/lo unchanged and suppress done; flush takes priority over start_E on the same edge.
REQ-025 When DATA_W×DATA_W → 2·DATA_W arithmetic is performed, internal accumulators SHALL be 64 bits (multiply) and 33 bits (divide partial remainder); no truncation SHALL occur before FIX.

Reset
REQ-026 When rst_n is low at a clk edge, the block SHALL force state to IDLE, counter, hi, lo, busy and done to 0, and discard all operand registers, including in mid-operation.
REQ-027 The reset condition SHALL take priority over flush and start_E.

Configuration
REQ-028 When MULDIV_FAST_MULT_EN is defined, MULT/MULTU SHALL compute the full product combinationally at acceptance, skip ITER and go straight to FIX: busy high one cycle, hi/lo valid after edge t0+1, done one cycle later.
REQ-029 When MULDIV_FAST_MULT_EN is undefined, multiply SHALL use the 32-cycle iterative path; divide timing SHALL be unaffected in both cases.

Verification
REQ-030 Bench SHALL cover: MULT 32'hFFFF_FFFE × 32'h0000_0003 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, busy for 34 cycles, one done pulse.
REQ-031 Bench SHALL cover: MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF → hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-032 Bench SHALL cover: DIV -7 ÷ 2 → lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; and DIVU 100 ÷ 0 → lo=32'hFFFF_FFFF, hi=100.
REQ-033 Bench SHALL cover: DIVU started, flush at iteration 10 → busy low next cycle, no done, hi/lo keep their prior values; a new start the following cycle completes normally.
REQ-034 Bench SHALL cover: MTLO 32'h1234_5678 → lo updated the next cycle, busy never high; rst_n low during ITER → hi=lo=0, state IDLE.
REQ-035 Bench SHALL cover, with MULDIV_FAST_MULT_EN defined: MULT 7 × -3 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB after edge t0+1, busy high one cycle.
